// File: rtl/button_bank_pkg.sv
// button_bank_pkg: shared channel state encoding and hold-counter width for button_bank.
package button_bank_pkg;
   typedef enum logic [1:0] {REL, HOLD, LONG} chan_state_t;
   localparam int HOLD_W = 8;
endpackage

// File: rtl/button_bank_chan.sv
// button_bank_chan: one button channel - synchroniser, debounce, press/release/long-press FSM.
// Auto-repeat is built only when BUTTON_BANK_REPEAT_EN is defined.
module button_bank_chan
   import button_bank_pkg::*;
#(
   parameter int CNTR_WIDTH = 20,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int LONG_TICKS = 100
`ifdef BUTTON_BANK_REPEAT_EN
   , parameter int REPEAT_TICKS = 10
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic tick,
   output logic pressed,
   output logic released,
   output logic long_press,
   output logic level
);
   logic s0, s1, btn, commit, press_c, rel_c, long_n, rpt_n;
   logic [CNTR_WIDTH-1:0] cnt;
   logic [HOLD_W-1:0] hold, hold_n;
   chan_state_t state, state_n;
`ifdef BUTTON_BANK_REPEAT_EN
   logic [HOLD_W-1:0] rep, rep_n;
`endif
   assign btn     = s1 ^ ACTIVE_LOW;
   assign commit  = (btn != level) && (&cnt);
   assign press_c = commit & btn;
   assign rel_c   = commit & ~btn;
   always_ff @(posedge clk) begin
      if (rst) begin
         s0         <= ACTIVE_LOW;
         s1         <= ACTIVE_LOW;
         cnt        <= '0;
         level      <= 1'b0;
         state      <= REL;
         hold       <= '0;
         pressed    <= 1'b0;
         released   <= 1'b0;
         long_press <= 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
         rep        <= '0;
`endif
      end else begin
         s0         <= raw;
         s1         <= s0;
         cnt        <= (btn == level || commit) ? '0 : cnt + 1'b1;
         level      <= commit ? btn : level;
         state      <= state_n;
         hold       <= hold_n;
         pressed    <= press_c | rpt_n;
         released   <= rel_c;
         long_press <= long_n;
`ifdef BUTTON_BANK_REPEAT_EN
         rep        <= rep_n;
`endif
      end
   end
   // A tick fires long_press only once the hold count already sits at LONG_TICKS,
   // so a hold lasts LONG_TICKS..LONG_TICKS+1 tick periods; release always wins.
   always_comb begin
      state_n = state;
      hold_n  = hold;
      long_n  = 1'b0;
      rpt_n   = 1'b0;
      case (state)
         REL: begin
            hold_n = '0;
            if (press_c) state_n = HOLD;
         end
         HOLD: begin
            if (rel_c) begin
               state_n = REL;
               hold_n  = '0;
            end else if (tick) begin
               if (hold == HOLD_W'(LONG_TICKS)) begin
                  state_n = LONG;
                  long_n  = 1'b1;
               end else hold_n = hold + 1'b1;
            end
         end
         LONG: begin
            if (rel_c) begin
               state_n = REL;
               hold_n  = '0;
            end
         end
         default: state_n = REL;
      endcase
`ifdef BUTTON_BANK_REPEAT_EN
      rep_n = rep;
      if (state != LONG || rel_c) rep_n = '0;
      else if (tick) begin
         rpt_n = (rep + 1'b1) == HOLD_W'(REPEAT_TICKS);
         rep_n = rpt_n ? '0 : rep + 1'b1;
      end
`endif
   end
endmodule

// File: rtl/button_bank.sv
// button_bank: NUM_BTN debounced button channels sharing one prescaler tick.
// Optional auto-repeat: define BUTTON_BANK_REPEAT_EN (adds REPEAT_TICKS).
module button_bank
   import button_bank_pkg::*;
#(
   parameter int NUM_BTN    = 4,
   parameter int CNTR_WIDTH = 20,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int TICK_WIDTH = 16,
   parameter int LONG_TICKS = 100
`ifdef BUTTON_BANK_REPEAT_EN
   , parameter int REPEAT_TICKS = 10
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] pressed,
   output logic [NUM_BTN-1:0] released,
   output logic [NUM_BTN-1:0] long_press,
   output logic [NUM_BTN-1:0] level
);
   logic [TICK_WIDTH-1:0] presc;
   logic tick;
   assign tick = &presc;
   always_ff @(posedge clk) presc <= rst ? '0 : presc + 1'b1;
   for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
      button_bank_chan #(
         .CNTR_WIDTH(CNTR_WIDTH),
         .ACTIVE_LOW(ACTIVE_LOW),
         .LONG_TICKS(LONG_TICKS)
`ifdef BUTTON_BANK_REPEAT_EN
         , .REPEAT_TICKS(REPEAT_TICKS)
`endif
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .raw       (btn_raw[g]),
         .tick      (tick),
         .pressed   (pressed[g]),
         .released  (released[g]),
         .long_press(long_press[g]),
         .level     (level[g])
      );
   end
endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: scoreboard bench; expected pulses carry cycle windows and are matched in order.
module tb_button_bank;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] btn_raw = 2'b11;
   logic [1:0] pressed, released, long_press, level;
   typedef struct {int kind; int ch; int lo; int hi;} ev_t;
   ev_t exp_q[$];
   ev_t obs_q[$];
   int  cyc = 0;
   int  vectors = 0;
   int  miscompares = 0;

   button_bank #(
      .NUM_BTN(2), .CNTR_WIDTH(3), .ACTIVE_LOW(1'b1), .TICK_WIDTH(2), .LONG_TICKS(3)
`ifdef BUTTON_BANK_REPEAT_EN
      , .REPEAT_TICKS(2)
`endif
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .pressed(pressed),
      .released(released), .long_press(long_press), .level(level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // kind 0 = pressed, 1 = released, 2 = long_press
   always @(negedge clk)
      for (int c = 0; c < 2; c++) begin
         if (pressed[c])    obs_q.push_back('{0, c, cyc, cyc});
         if (released[c])   obs_q.push_back('{1, c, cyc, cyc});
         if (long_press[c]) obs_q.push_back('{2, c, cyc, cyc});
      end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_ev(input int kind, input int ch, input int lo, input int hi);
      exp_q.push_back('{kind, ch, lo, hi});
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic check_events(input string tag);
      int dl = 0;
      ev_t e, o;
      foreach (exp_q[i]) if (exp_q[i].hi > dl) dl = exp_q[i].hi;
      while (cyc <= dl) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '{-1, -1, -1, -1};
         vectors++;
         assert (o.kind === e.kind && o.ch === e.ch && o.lo >= e.lo && o.lo <= e.hi) else begin
            miscompares++;
            $error("FAIL %s: got kind %0d ch %0d cyc %0d, want kind %0d ch %0d cyc %0d..%0d",
                   tag, o.kind, o.ch, o.lo, e.kind, e.ch, e.lo, e.hi);
         end
      end
      vectors++;
      assert (obs_q.size() === 0) else begin
         miscompares++;
         $error("FAIL %s extra: %0d unexpected pulses, first kind %0d ch %0d cyc %0d",
                tag, obs_q.size(), obs_q[0].kind, obs_q[0].ch, obs_q[0].lo);
         obs_q.delete();
      end
   endtask

   initial begin
      int t;
      step(3);
      chk("reset", {pressed, released, long_press, level}, 8'h00);
      rst = 1'b0;
      step(5);
      check_events("idle");
      // clean press held into a long press, then release
      t = cyc;
      btn_raw[0] = 1'b0;
      expect_ev(0, 0, t + 9, t + 11);
      expect_ev(2, 0, t + 22, t + 27);
`ifdef BUTTON_BANK_REPEAT_EN
      for (int k = 1; k <= 3; k++) expect_ev(0, 0, t + 22 + 8 * k, t + 27 + 8 * k);
`endif
      step(20);
      chk("level_held", {6'd0, level}, 8'h01);
      step(22);
      btn_raw[0] = 1'b1;
      expect_ev(1, 0, t + 51, t + 53);
      check_events("long");
      chk("level_rel", {6'd0, level}, 8'h00);
      step(20);
      check_events("after_long");
      // short press: released before any long_press
      t = cyc;
      btn_raw[0] = 1'b0;
      expect_ev(0, 0, t + 9, t + 11);
      step(12);
      btn_raw[0] = 1'b1;
      expect_ev(1, 0, t + 21, t + 23);
      check_events("short");
      step(5);
      // bounce every 3 cycles, then settle pressed
      t = cyc;
      for (int i = 0; i < 10; i++) begin
         btn_raw[0] = ~btn_raw[0];
         step(3);
      end
      btn_raw[0] = 1'b0;
      expect_ev(0, 0, t + 39, t + 41);
      check_events("bounce");
      // reset while in HOLD with the pin still held
      rst = 1'b1;
      step(1);
      chk("mid_reset", {pressed, released, long_press, level}, 8'h00);
      rst = 1'b0;
      t = cyc;
      expect_ev(0, 0, t + 9, t + 11);
      check_events("post_reset");
      t = cyc;
      btn_raw[0] = 1'b1;
      expect_ev(1, 0, t + 9, t + 11);
      check_events("post_reset_rel");
      // both channels together
      t = cyc;
      btn_raw = 2'b00;
      expect_ev(0, 0, t + 9, t + 11);
      expect_ev(0, 1, t + 9, t + 11);
      step(12);
      chk("level_both", {6'd0, level}, 8'h03);
      btn_raw = 2'b11;
      expect_ev(1, 0, t + 21, t + 23);
      expect_ev(1, 1, t + 21, t + 23);
      check_events("dual");
      step(10);
      check_events("quiet");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
